coklu_yazmac_obegi: RTL and testbench

Parametrised multi-read-port integer register file for the core's decode/writeback path. Adds a configurable read-port count, optional hardwired-zero register, write-to-read bypass, a per-register busy scoreboard for the issue stage, and a sequential one-entry-per-cycle clear engine, so the array can map to RAM-style storage. It is the drop-in successor of the current 2-read/1-write register file.

---
 rtl/coklu_yazmac_obegi_pkg.sv | 20 ++
 rtl/yazmac_temizleyici.sv | 55 +++++
 rtl/coklu_yazmac_obegi.sv | 88 ++++++++
 tb/tb_coklu_yazmac_obegi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/coklu_yazmac_obegi_pkg.sv
// Shared definitions for the register file, decode and issue stage.
// Holds the clear/normal state encoding, default sizes and the address width helper.
package coklu_yazmac_obegi_pkg;

    localparam int VARSAYILAN_VERI_BIT     = 32;
    localparam int VARSAYILAN_YAZMAC_SAYI  = 32;
    localparam int VARSAYILAN_OKUMA_PORT   = 2;
    localparam int VARSAYILAN_SIFIR_YAZMAC = 1;
    localparam int VARSAYILAN_ATLAMA       = 1;

    typedef enum logic {
        TEMIZLE = 1'b0,
        HAZIR   = 1'b1
    } durum_t;

    function automatic int adres_bit_hesapla(input int sayi);
        return (sayi < 2) ? 1 : $clog2(sayi);
    endfunction

endpackage

// File: rtl/yazmac_temizleyici.sv
// Clear sequencer: walks every entry once after reset or a clear request, then reports ready.
// Latency: ready exactly YAZMAC_SAYI cycles after the clear starts.
// No backpressure; a clear request while clearing is ignored, reset restarts the walk.
module yazmac_temizleyici
    import coklu_yazmac_obegi_pkg::*;
#(
    parameter int YAZMAC_SAYI = VARSAYILAN_YAZMAC_SAYI,
    parameter int ADRES_BIT   = adres_bit_hesapla(YAZMAC_SAYI)
) (
    input  logic                 clk_g,
    input  logic                 rst_g,
    input  logic                 temizle_g,
    output logic                 hazir_c,
    output logic                 temizle_yaz_c,
    output logic [ADRES_BIT-1:0] temizle_adres_c
);

    localparam logic [ADRES_BIT-1:0] SON_ADRES = ADRES_BIT'(YAZMAC_SAYI - 1);

    durum_t               durum, durum_sonraki;
    logic [ADRES_BIT-1:0] sayac, sayac_sonraki;

    always_ff @(posedge clk_g) begin
        if (rst_g) begin
            durum <= TEMIZLE;
            sayac <= '0;
        end else begin
            durum <= durum_sonraki;
            sayac <= sayac_sonraki;
        end
    end

    always_comb begin
        durum_sonraki = durum;
        sayac_sonraki = sayac;
        case (durum)
            TEMIZLE: begin
                sayac_sonraki = sayac + ADRES_BIT'(1);
                if (sayac == SON_ADRES) durum_sonraki = HAZIR;
            end
            HAZIR: begin
                if (temizle_g) begin
                    durum_sonraki = TEMIZLE;
                    sayac_sonraki = '0;
                end
            end
            default: durum_sonraki = TEMIZLE;
        endcase
    end

    assign hazir_c         = (durum == HAZIR);
    assign temizle_yaz_c   = (durum == TEMIZLE);
    assign temizle_adres_c = sayac;

endmodule

// File: rtl/coklu_yazmac_obegi.sv
// Multi-read-port register file with optional zero register, write bypass and busy scoreboard.
// Latency: reads combinational, writes and busy bits visible next cycle (bypass makes writes same-cycle).
// No backpressure; traffic is dropped while hazir_c is low.
module coklu_yazmac_obegi
    import coklu_yazmac_obegi_pkg::*;
#(
    parameter int VERI_BIT     = VARSAYILAN_VERI_BIT,
    parameter int YAZMAC_SAYI  = VARSAYILAN_YAZMAC_SAYI,
    parameter int ADRES_BIT    = adres_bit_hesapla(YAZMAC_SAYI),
    parameter int OKUMA_PORT   = VARSAYILAN_OKUMA_PORT,
    parameter int SIFIR_YAZMAC = VARSAYILAN_SIFIR_YAZMAC,
    parameter int ATLAMA       = VARSAYILAN_ATLAMA
) (
    input  logic                           clk_g,
    input  logic                           rst_g,
    input  logic [OKUMA_PORT*ADRES_BIT-1:0] oku_adres_g,
    output logic [OKUMA_PORT*VERI_BIT-1:0]  oku_deger_c,
    input  logic                           yaz_g,
    input  logic [ADRES_BIT-1:0]           yaz_adres_g,
    input  logic [VERI_BIT-1:0]            yaz_deger_g,
    input  logic                           ayir_g,
    input  logic [ADRES_BIT-1:0]           ayir_adres_g,
    input  logic                           temizle_g,
    output logic [YAZMAC_SAYI-1:0]         mesgul_c,
    output logic                           hazir_c
);

    logic [VERI_BIT-1:0]  kayit [YAZMAC_SAYI];
    logic                 temizle_yaz;
    logic [ADRES_BIT-1:0] temizle_adres;
    logic                 yaz_gecerli, ayir_gecerli;

    yazmac_temizleyici #(
        .YAZMAC_SAYI (YAZMAC_SAYI),
        .ADRES_BIT   (ADRES_BIT)
    ) u_temizleyici (
        .clk_g           (clk_g),
        .rst_g           (rst_g),
        .temizle_g       (temizle_g),
        .hazir_c         (hazir_c),
        .temizle_yaz_c   (temizle_yaz),
        .temizle_adres_c (temizle_adres)
    );

    // A clear request in the same cycle drops any write or reserve.
    assign yaz_gecerli  = hazir_c && yaz_g && !temizle_g &&
                          !((SIFIR_YAZMAC != 0) && (yaz_adres_g == '0));
    assign ayir_gecerli = hazir_c && ayir_g && !temizle_g &&
                          !((SIFIR_YAZMAC != 0) && (ayir_adres_g == '0));

    // Single write port and no reset so the array can map onto RAM.
    always_ff @(posedge clk_g) begin
        if (temizle_yaz)
            kayit[temizle_adres] <= '0;
        else if (yaz_gecerli)
            kayit[yaz_adres_g] <= yaz_deger_g;
    end

    // Reserve is applied after the write-clear so it wins on the same address.
    always_ff @(posedge clk_g) begin
        if (rst_g || !hazir_c || temizle_g) begin
            mesgul_c <= '0;
        end else begin
            if (yaz_gecerli)  mesgul_c[yaz_adres_g]  <= 1'b0;
            if (ayir_gecerli) mesgul_c[ayir_adres_g] <= 1'b1;
        end
    end

    for (genvar p = 0; p < OKUMA_PORT; p++) begin : g_oku
        logic [ADRES_BIT-1:0] adres;
        logic [VERI_BIT-1:0]  deger;

        assign adres = oku_adres_g[p*ADRES_BIT +: ADRES_BIT];

        always_comb begin
            deger = kayit[adres];
            if (!hazir_c)
                deger = '0;
            else if ((SIFIR_YAZMAC != 0) && (adres == '0))
                deger = '0;
            else if ((ATLAMA != 0) && yaz_g && (yaz_adres_g == adres))
                deger = yaz_deger_g;
        end

        assign oku_deger_c[p*VERI_BIT +: VERI_BIT] = deger;
    end

endmodule

// File: tb/tb_coklu_yazmac_obegi.sv
// Directed bench for coklu_yazmac_obegi: a 4-port bypassing instance and a 2-port non-bypassing
// instance share all inputs; expectations are queued by the stimulus and checked on the falling edge.
module tb_coklu_yazmac_obegi;

    logic         clk_g = 1'b0;
    logic         rst_g;
    logic [19:0]  oku_adres;
    logic [127:0] oku_a;
    logic [63:0]  oku_b;
    logic         yaz_g;
    logic [4:0]   yaz_adres;
    logic [31:0]  yaz_deger;
    logic         ayir_g;
    logic [4:0]   ayir_adres;
    logic         temizle_g;
    logic [31:0]  mesgul_a, mesgul_b;
    logic         hazir_a, hazir_b;

    always #5 clk_g = ~clk_g;

    coklu_yazmac_obegi #(
        .VERI_BIT(32), .YAZMAC_SAYI(32), .ADRES_BIT(5),
        .OKUMA_PORT(4), .SIFIR_YAZMAC(1), .ATLAMA(1)
    ) u_dut (
        .clk_g(clk_g), .rst_g(rst_g), .oku_adres_g(oku_adres), .oku_deger_c(oku_a),
        .yaz_g(yaz_g), .yaz_adres_g(yaz_adres), .yaz_deger_g(yaz_deger),
        .ayir_g(ayir_g), .ayir_adres_g(ayir_adres), .temizle_g(temizle_g),
        .mesgul_c(mesgul_a), .hazir_c(hazir_a)
    );

    coklu_yazmac_obegi #(
        .VERI_BIT(32), .YAZMAC_SAYI(32), .ADRES_BIT(5),
        .OKUMA_PORT(2), .SIFIR_YAZMAC(1), .ATLAMA(0)
    ) u_dut_nb (
        .clk_g(clk_g), .rst_g(rst_g), .oku_adres_g(oku_adres[9:0]), .oku_deger_c(oku_b),
        .yaz_g(yaz_g), .yaz_adres_g(yaz_adres), .yaz_deger_g(yaz_deger),
        .ayir_g(ayir_g), .ayir_adres_g(ayir_adres), .temizle_g(temizle_g),
        .mesgul_c(mesgul_b), .hazir_c(hazir_b)
    );

    // tur: 0 read A, 1 read B, 2 busy A, 3 ready A, 4 ready B, 5 busy B
    typedef struct {
        int          tur;
        int          port;
        logic [31:0] bek;
        string       ad;
    } beklenti_t;

    beklenti_t   q[$];
    beklenti_t   b;
    logic [31:0] gercek;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk_g) begin
        while (q.size() > 0) begin
            b = q.pop_front();
            case (b.tur)
                0:       gercek = oku_a[b.port*32 +: 32];
                1:       gercek = oku_b[b.port*32 +: 32];
                2:       gercek = mesgul_a;
                3:       gercek = {31'd0, hazir_a};
                4:       gercek = {31'd0, hazir_b};
                default: gercek = mesgul_b;
            endcase
            checks++;
            if (gercek !== b.bek) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", b.ad, gercek, b.bek);
            end
        end
    end

    task automatic bekle(input int tur, input int port, input logic [31:0] bek, input string ad);
        beklenti_t e;
        e.tur = tur; e.port = port; e.bek = bek; e.ad = ad;
        q.push_back(e);
    endtask

    task automatic tik();
        @(posedge clk_g);
        #1;
    endtask

    task automatic oku_ayarla(input int p, input int a);
        oku_adres[p*5 +: 5] = a[4:0];
    endtask

    task automatic temizlik_bekle(input string ad);
        for (int i = 1; i <= 32; i++) begin
            tik();
            bekle(3, 0, (i == 32) ? 32'd1 : 32'd0, $sformatf("%s_hazir_c%0d", ad, i));
            if (i == 5) begin
                for (int p = 0; p < 4; p++) bekle(0, p, 32'd0, $sformatf("%s_okuma_sirasinda_p%0d", ad, p));
                bekle(2, 0, 32'd0, $sformatf("%s_mesgul_sirasinda", ad));
            end
            if (i == 32) bekle(4, 0, 32'd1, $sformatf("%s_hazir_nb", ad));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_g = 1'b1; oku_adres = '0; yaz_g = 1'b0; yaz_adres = '0; yaz_deger = '0;
        ayir_g = 1'b0; ayir_adres = '0; temizle_g = 1'b0;

        // reset and initial clear
        tik();
        rst_g = 1'b0;
        for (int p = 0; p < 4; p++) oku_ayarla(p, p + 1);
        bekle(3, 0, 32'd0, "reset_hazir");
        bekle(2, 0, 32'd0, "reset_mesgul");
        for (int p = 0; p < 4; p++) bekle(0, p, 32'd0, $sformatf("reset_oku_p%0d", p));
        temizlik_bekle("ilk");

        for (int a = 0; a < 32; a += 4) begin
            for (int p = 0; p < 4; p++) begin
                oku_ayarla(p, a + p);
                bekle(0, p, 32'd0, $sformatf("temiz_r%0d", a + p));
            end
            tik();
        end

        // write r5 with same-cycle read, neighbouring port must not see bypass
        oku_ayarla(0, 5); oku_ayarla(1, 6);
        yaz_g = 1'b1; yaz_adres = 5'd5; yaz_deger = 32'hDEADBEEF;
        bekle(0, 0, 32'hDEADBEEF, "atlama_r5");
        bekle(0, 1, 32'd0, "atlama_yok_r6");
        bekle(1, 0, 32'd0, "atlamasiz_r5_ayni");
        tik();
        yaz_g = 1'b0;
        bekle(0, 0, 32'hDEADBEEF, "r5_sonra");
        bekle(1, 0, 32'hDEADBEEF, "atlamasiz_r5_sonra");
        tik();

        // zero register
        oku_ayarla(0, 0); oku_ayarla(1, 0);
        yaz_g = 1'b1; yaz_adres = 5'd0; yaz_deger = 32'h1234;
        bekle(0, 0, 32'd0, "r0_ayni");
        tik();
        yaz_g = 1'b0;
        bekle(0, 0, 32'd0, "r0_sonra");
        bekle(1, 1, 32'd0, "r0_sonra_nb");
        ayir_g = 1'b1; ayir_adres = 5'd0;
        tik();
        ayir_g = 1'b0;
        bekle(2, 0, 32'd0, "ayir_r0");

        // busy scoreboard on r7
        ayir_g = 1'b1; ayir_adres = 5'd7;
        bekle(2, 0, 32'd0, "ayir_r7_ayni");
        tik();
        ayir_g = 1'b0;
        bekle(2, 0, 32'h80, "ayir_r7");
        bekle(5, 0, 32'h80, "ayir_r7_nb");
        yaz_g = 1'b1; yaz_adres = 5'd7; yaz_deger = 32'h44;
        tik();
        yaz_g = 1'b0;
        oku_ayarla(1, 7);
        bekle(2, 0, 32'd0, "yaz_r7_mesgul");
        bekle(1, 1, 32'h44, "yaz_r7");
        yaz_g = 1'b1; yaz_deger = 32'h55; ayir_g = 1'b1; ayir_adres = 5'd7;
        tik();
        yaz_g = 1'b0; ayir_g = 1'b0;
        bekle(2, 0, 32'h80, "yaz_ayir_r7_mesgul");
        bekle(1, 1, 32'h55, "yaz_ayir_r7");

        // software clear with pending write
        yaz_g = 1'b1; yaz_adres = 5'd3; yaz_deger = 32'hA;
        tik();
        yaz_g = 1'b0; ayir_g = 1'b1; ayir_adres = 5'd3;
        tik();
        ayir_g = 1'b0;
        oku_ayarla(0, 3);
        bekle(2, 0, 32'h88, "ayir_r3_mesgul");
        bekle(1, 0, 32'hA, "r3_once");
        temizle_g = 1'b1; yaz_g = 1'b1; yaz_adres = 5'd9; yaz_deger = 32'h99;
        tik();
        temizle_g = 1'b0; yaz_g = 1'b0;
        bekle(2, 0, 32'd0, "temizle_mesgul");
        bekle(3, 0, 32'd0, "temizle_hazir");
        temizlik_bekle("yazilim");
        oku_ayarla(0, 3); oku_ayarla(1, 9);
        bekle(0, 0, 32'd0, "temizle_r3");
        bekle(1, 1, 32'd0, "temizle_r9");
        bekle(2, 0, 32'd0, "temizle_sonra_mesgul");
        tik();

        // reset in the middle of a clear
        rst_g = 1'b1;
        tik();
        rst_g = 1'b0;
        bekle(3, 0, 32'd0, "rst_hazir");
        for (int i = 0; i < 10; i++) tik();
        rst_g = 1'b1;
        tik();
        rst_g = 1'b0;
        bekle(3, 0, 32'd0, "rst_orta_hazir");
        temizlik_bekle("rst_orta");

        // four ports on the same register
        yaz_g = 1'b1; yaz_adres = 5'd12; yaz_deger = 32'h77;
        tik();
        yaz_g = 1'b0;
        for (int p = 0; p < 4; p++) begin
            oku_ayarla(p, 12);
            bekle(0, p, 32'h77, $sformatf("dort_port_p%0d", p));
        end
        bekle(1, 1, 32'h77, "dort_port_nb");
        tik();
        tik();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL kuyruk_bos: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
